// File: rtl/mem_wide_narrow_arbiter.sv
// Wide/narrow memory arbiter: drives the registered wide-select for the bank mux
// and tracks fixed-latency read responses for both sides.
module mem_wide_narrow_arbiter #(
    parameter int unsigned NrPorts       = 4,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned MaxWideBurst  = 8,
    parameter int unsigned MaxWideWait   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 wide_q_valid_i,
    input  logic                                 wide_q_write_i,
    output logic                                 wide_q_ready_o,
    input  logic [NrPorts-1:0]                   narrow_q_valid_i,
    input  logic [NrPorts-1:0]                   narrow_q_ready_i,
    input  logic [NrPorts-1:0]                   narrow_q_write_i,
    output logic                                 sel_wide_o,
    output logic                                 wide_p_valid_o,
    output logic [NrPorts-1:0]                   narrow_p_valid_o,
    output logic [$clog2(MemoryLatency+1)-1:0]   wide_outstanding_o
);

    localparam int unsigned CntW = $clog2(MemoryLatency + 1);
    localparam int unsigned BW   = $clog2(MaxWideBurst + 1);
    localparam int unsigned WW   = $clog2(MaxWideWait + 1);

    typedef enum logic {
        S_NARROW = 1'b0,
        S_WIDE   = 1'b1
    } state_e;

    state_e r_state, w_state_nxt;
    logic [BW-1:0] r_burst, w_burst_nxt;
    logic [WW-1:0] r_wait, w_wait_nxt;

    logic [MemoryLatency-1:0]              r_wide_sr;
    logic [MemoryLatency-1:0][NrPorts-1:0] r_nar_sr;

    logic               w_narrow_pend;
    logic               w_wide_hs;
    logic [NrPorts-1:0] w_nar_hs;
    logic [CntW-1:0]    w_outstanding;

    assign w_narrow_pend = |narrow_q_valid_i;
    assign sel_wide_o    = (r_state == S_WIDE);
    assign wide_q_ready_o = sel_wide_o;

    assign w_wide_hs = wide_q_valid_i & sel_wide_o & ~wide_q_write_i;
    assign w_nar_hs  = narrow_q_valid_i & narrow_q_ready_i & ~narrow_q_write_i;

    // Burst limit uses >= so a saturated counter still yields to late narrow traffic.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_wait_nxt  = '0;
        unique case (r_state)
            S_NARROW: begin
                if (wide_q_valid_i) begin
                    if (!w_narrow_pend || r_wait == WW'(MaxWideWait - 1)) begin
                        w_state_nxt = S_WIDE;
                    end else begin
                        w_wait_nxt = r_wait + WW'(1);
                    end
                end
            end
            S_WIDE: begin
                if (!wide_q_valid_i ||
                    (w_narrow_pend && r_burst >= BW'(MaxWideBurst - 1))) begin
                    w_state_nxt = S_NARROW;
                    w_burst_nxt = '0;
                end else if (r_burst != BW'(MaxWideBurst)) begin
                    w_burst_nxt = r_burst + BW'(1);
                end
            end
            default: begin
                w_state_nxt = S_NARROW;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_NARROW;
            r_burst   <= '0;
            r_wait    <= '0;
            r_wide_sr <= '0;
            r_nar_sr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst     <= w_burst_nxt;
            r_wait      <= w_wait_nxt;
            r_wide_sr[0] <= w_wide_hs;
            r_nar_sr[0]  <= w_nar_hs;
            for (int i = 1; i < MemoryLatency; i++) begin
                r_wide_sr[i] <= r_wide_sr[i-1];
                r_nar_sr[i]  <= r_nar_sr[i-1];
            end
        end
    end

    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < MemoryLatency; i++) begin
            w_outstanding = w_outstanding + CntW'(r_wide_sr[i]);
        end
    end

    assign wide_p_valid_o     = r_wide_sr[MemoryLatency-1];
    assign narrow_p_valid_o   = r_nar_sr[MemoryLatency-1];
    assign wide_outstanding_o = w_outstanding;

endmodule

// File: doc/mem_wide_narrow_arbiter.md
Name: mem_wide_narrow_arbiter

Overview:
- Control stage directly upstream of the wide/narrow memory mux; generates its wide-select signal.
- Arbitrates between one wide (DMA) requester and NrPorts narrow requesters with bounded starvation in both directions.
- Drives the registered select, so the wide port always sees the immediate grant the mux requires.
- Tracks fixed-latency read responses and flags when wide and narrow response data is valid.

Parameters:
NrPorts, 4, number of narrow ports/banks (>=1).
MemoryLatency, 1, cycles from request handshake to response data (>=1).
MaxWideBurst, 8, maximum consecutive wide handshakes while any narrow request is pending (>=1).
MaxWideWait, 4, maximum cycles a pending wide request waits in NARROW (>=1).

Ports:
clk_i  in  1  clock; single clock domain.
rst_i  in  1  reset, synchronous, active-high.
wide_q_valid_i  in  1  wide requester has a request.
wide_q_write_i  in  1  wide request is a write; qualified by wide_q_valid_i.
wide_q_ready_o  out  1  wide grant; equals sel_wide_o.
narrow_q_valid_i  in  NrPorts  narrow request pending per port.
narrow_q_ready_i  in  NrPorts  narrow grant per port, taken after the mux.
narrow_q_write_i  in  NrPorts  narrow request is a write.
sel_wide_o  out  1  to mux select; 1 = wide owns all banks.
wide_p_valid_o  out  1  wide read data valid on the mux wide response this cycle.
narrow_p_valid_o  out  NrPorts  narrow read data valid per port.
wide_outstanding_o  out  $clog2(MemoryLatency+1)  wide reads in flight.

Behaviour:
- Interface: one clock; synchronous active-high reset.
- sel_wide_o comes directly from a flop; no combinational path from any input.
- Reset values (all outputs): sel_wide_o=0, wide_q_ready_o=0, wide_p_valid_o=0, narrow_p_valid_o=0, wide_outstanding_o=0.
- Reset state: FSM=NARROW, burst_cnt=0, wait_cnt=0, all shift registers cleared.
- Reset mid-operation: in-flight valid flags are discarded; no valid pulse appears after reset.
- FSM state NARROW (sel=0):
  - wait_cnt increments each cycle wide_q_valid_i=1 and the FSM stays; cleared otherwise.
  - Go to WIDE when wide_q_valid_i && (narrow_q_valid_i==0 || wait_cnt==MaxWideWait-1).
  - A wide request arriving at cycle t with no narrow traffic is granted at t+1 (1-cycle switch latency).
- FSM state WIDE (sel=1):
  - Each cycle with wide_q_valid_i=1 is a handshake; burst_cnt increments, saturating at MaxWideBurst.
  - Go to NARROW when wide_q_valid_i=0, OR when |narrow_q_valid_i && burst_cnt==MaxWideBurst-1 with a handshake this cycle.
  - burst_cnt clears on leaving WIDE.
  - With no narrow traffic, WIDE holds indefinitely.
- Simultaneous wide drop and burst limit: both lead to NARROW; no extra cycles are spent.
- Handshake definitions:
  - Wide read handshake: wide_q_valid_i & sel_wide_o & !wide_q_write_i.
  - Narrow read handshake, port i: narrow_q_valid_i[i] & narrow_q_ready_i[i] & !narrow_q_write_i[i].
- Response tracking:
  - Each handshake enters a MemoryLatency-deep shift register.
  - The valid output is the last stage, asserted exactly MemoryLatency cycles after the handshake cycle.
  - Writes produce no valid pulse.
- wide_outstanding_o = popcount of the wide shift register; it never exceeds MemoryLatency.
- A select switch does not cancel in-flight responses: valids still fire at their scheduled cycle.

Test Plan:
- Reset: assert rst_i for 2 cycles during a WIDE burst -> next cycle sel_wide_o=0, every valid output 0 for MemoryLatency+2 cycles.
- Idle wide access: narrow idle, wide_q_valid_i high at cycle 10 for 3 cycles -> sel_wide_o=1 at cycles 11-13, 0 at 14.
- Wide reads, MemoryLatency=2: handshakes at cycles 11-13 -> wide_p_valid_o high at cycles 13-15; wide_outstanding_o peaks at 2.
- Burst limit, MaxWideBurst=8: wide continuously valid, narrow port 0 valid from cycle 0 -> exactly 8 wide handshakes, then sel=0 for >=1 cycle, then back to WIDE within MaxWideWait=4 cycles.
- Wide starvation bound: all narrow ports continuously valid, wide valid from cycle 5 -> sel_wide_o=1 by cycle 9.
- Mixed traffic: narrow write on port 1 and narrow read on port 2 at cycle 3 -> narrow_p_valid_o[2] pulses at cycle 3+MemoryLatency, no pulse on port 1; wide write handshakes never raise wide_p_valid_o.
